matmul_stream_array: RTL and testbench

- Parametrised N×N output-stationary MAC array that computes C = W·X over a programmable inner dimension K.
- Operands stream in one beat per cycle on a valid/ready interface. Beat t carries column t of W (one element per row) and row t of X (one element per column).
- When accumulation finishes, the N² results are unloaded serially on a valid/ready output in row-major order. The block replaces hand-driven per-cell load/clear vectors with an internal sequencer and sits between the operand fetch logic and the result writeback.

---
 rtl/matmul_stream_array.sv | 130 +++++++++++++
 tb/tb_matmul_stream_array.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_stream_array.sv
// Output-stationary N x N MAC array computing C = W*X over a programmable inner dimension,
// streamed in on valid/ready and unloaded row-major. Define MATMUL_STREAM_SIGNED_EN for signed.
module matmul_stream_array #(
  parameter int unsigned N  = 3,
  parameter int unsigned DW = 4,
  parameter int unsigned KW = 4,
  localparam int unsigned AW = 2 * DW + KW,
  localparam int unsigned IW = (N * N > 1) ? $clog2(N * N) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [KW-1:0]   k_len_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [N*DW-1:0] w_vec_i,
  input  logic [N*DW-1:0] x_vec_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [AW-1:0]   out_data_o,
  output logic [IW-1:0]   out_index_o,
  output logic            out_last_o,
  output logic            busy_o
);

  localparam logic [IW-1:0] LastIdx = IW'(N * N - 1);

  typedef enum logic [1:0] {StIdle, StAccum, StUnload} state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   k_len_q, k_len_d;
  logic [KW-1:0]   beat_q, beat_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            out_valid_q, out_valid_d;
  logic [AW-1:0]   acc_q [N*N];
  logic [AW-1:0]   acc_d [N*N];
  logic            accept;

  function automatic logic [AW-1:0] mac_prod(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef MATMUL_STREAM_SIGNED_EN
    logic [AW-1:0] a_ext;
    logic [AW-1:0] b_ext;
    a_ext = {{(AW - DW){a[DW-1]}}, a};
    b_ext = {{(AW - DW){b[DW-1]}}, b};
    return a_ext * b_ext;
`else
    return AW'(a) * AW'(b);
`endif
  endfunction

  assign in_ready_o = (state_q == StAccum);
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    state_d     = state_q;
    k_len_d     = k_len_q;
    beat_d      = beat_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    acc_d       = acc_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          k_len_d = k_len_i;
          beat_d  = '0;
          for (int unsigned c = 0; c < N * N; c++) begin
            acc_d[c] = '0;
          end
          state_d = (k_len_i == '0) ? StUnload : StAccum;
        end
      end
      StAccum: begin
        if (accept) begin
          beat_d = beat_q + KW'(1);
          for (int unsigned i = 0; i < N; i++) begin
            for (int unsigned j = 0; j < N; j++) begin
              acc_d[i*N+j] = acc_q[i*N+j] + mac_prod(w_vec_i[i*DW +: DW], x_vec_i[j*DW +: DW]);
            end
          end
          if (beat_q == k_len_q - KW'(1)) begin
            state_d = StUnload;
          end
        end
      end
      StUnload: begin
        // First UNLOAD cycle only arms the output so the final beat's sums have settled.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          idx_d       = '0;
        end else if (out_ready_i) begin
          if (idx_q == LastIdx) begin
            state_d     = StIdle;
            out_valid_d = 1'b0;
            idx_d       = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      k_len_q     <= '0;
      beat_q      <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      for (int unsigned c = 0; c < N * N; c++) begin
        acc_q[c] <= '0;
      end
    end else begin
      state_q     <= state_d;
      k_len_q     <= k_len_d;
      beat_q      <= beat_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_index_o = idx_q;
  assign out_data_o  = out_valid_q ? acc_q[idx_q] : '0;
  assign out_last_o  = out_valid_q && (idx_q == LastIdx);
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_matmul_stream_array.sv
// Scoreboard bench for matmul_stream_array: expected C pushed when operands are chosen,
// popped on each output handshake.
module tb_matmul_stream_array;
  localparam int N  = 3;
  localparam int DW = 4;
  localparam int KW = 4;
  localparam int AW = 2 * DW + KW;
  localparam int IW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [KW-1:0]   k_len = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [N*DW-1:0] w_vec = '0;
  logic [N*DW-1:0] x_vec = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [AW-1:0]   out_data;
  logic [IW-1:0]   out_index;
  logic            out_last;
  logic            busy;

  int checks = 0;
  int failures = 0;
  logic [AW-1:0] exp_q[$];
  int wb[16][3];
  int xb[16][3];

  matmul_stream_array #(.N(N), .DW(DW), .KW(KW)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .k_len_i    (k_len),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .w_vec_i    (w_vec),
    .x_vec_i    (x_vec),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .out_index_o(out_index),
    .out_last_o (out_last),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  function automatic int elem(input int v);
`ifdef MATMUL_STREAM_SIGNED_EN
    return (v > 7) ? v - 16 : v;
`else
    return v;
`endif
  endfunction

  task automatic push_expected(input int k);
    int s;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int t = 0; t < k; t++) s += elem(wb[t][i]) * elem(xb[t][j]);
        exp_q.push_back(AW'(s));
      end
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input int t);
    for (int i = 0; i < N; i++) begin
      w_vec[i*DW +: DW] = DW'(wb[t][i]);
      x_vec[i*DW +: DW] = DW'(xb[t][i]);
    end
  endtask

  task automatic run_job(input int k, input bit stall_in, input bit stall_out,
                         input bit start_mid, input string name);
    int t, cyc, n, held, first_valid;
    bit hs, tog;
    push_expected(k);
    start = 1'b1;
    k_len = KW'(k);
    tick;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL %s busy_rise: got %b want 1", name, busy);
    end
    if (k > 0) begin
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL %s in_ready_latency: got %b want 1", name, in_ready);
      end
    end
    t = 0;
    cyc = 0;
    tog = 1'b1;
    while (t < k && cyc < 200) begin
      in_valid = stall_in ? tog : 1'b1;
      tog = !tog;
      set_beat(t);
      hs = in_valid && in_ready;
      tick;
      if (hs) t++;
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (t < k) begin
      failures++;
      $display("FAIL %s beat_timeout: got %0d beats want %0d", name, t, k);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s in_ready_drop: got %b want 0", name, in_ready);
    end
    n = 0;
    cyc = 0;
    held = 0;
    first_valid = -1;
    while (n < N * N && cyc < 300) begin
      out_ready = 1'b1;
      start = start_mid && out_valid && (n == 2 || n == N * N - 1);
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (stall_out && out_valid && out_index == 4 && held < 5) begin
        out_ready = 1'b0;
        held++;
        checks++;
        if (out_data !== exp_q[0] || out_index !== 4'd4) begin
          failures++;
          $display("FAIL %s hold_stable: got data %0d idx %0d want data %0d idx 4",
                   name, out_data, out_index, exp_q[0]);
        end
      end
      hs = out_valid && out_ready;
      if (hs) begin
        logic [AW-1:0] e;
        e = exp_q.pop_front();
        checks++;
        if (out_data !== e || out_index !== IW'(n) || out_last !== (n == N * N - 1)) begin
          failures++;
          $display("FAIL %s result[%0d]: got data %0d idx %0d last %b want data %0d idx %0d last %b",
                   name, n, out_data, out_index, out_last, e, n, (n == N * N - 1));
        end
        n++;
      end
      tick;
      cyc++;
    end
    out_ready = 1'b0;
    start = 1'b0;
    checks++;
    if (n < N * N) begin
      failures++;
      $display("FAIL %s unload_timeout: got %0d results want %0d", name, n, N * N);
    end
    checks++;
    if (first_valid != 1) begin
      failures++;
      $display("FAIL %s out_latency: got %0d want 1 cycle after UNLOAD entry", name, first_valid);
    end
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s busy_drop: got busy %b valid %b want 0 0", name, busy, out_valid);
    end
    if (stall_out) begin
      checks++;
      if (held != 5) begin
        failures++;
        $display("FAIL %s hold_cycles: got %0d want 5", name, held);
      end
    end
    tick;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s stays_idle: got busy %b valid %b want 0 0", name, busy, out_valid);
    end
  endtask

  task automatic load_identity;
    for (int t = 0; t < N; t++) begin
      for (int i = 0; i < N; i++) begin
        wb[t][i] = 3 * i + t + 1;
        xb[t][i] = (t == i) ? 1 : 0;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick;
    tick;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 ||
        out_index !== '0 || out_last !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got busy %b rdy %b vld %b data %0d idx %0d last %b want all 0",
               busy, in_ready, out_valid, out_data, out_index, out_last);
    end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_identity;
    load_identity();
    run_job(3, 1'b0, 1'b0, 1'b0, "identity");
  endtask

  task automatic test_kzero;
    run_job(0, 1'b0, 1'b0, 1'b0, "kzero");
  endtask

  task automatic test_max;
    for (int t = 0; t < 15; t++) begin
      for (int i = 0; i < N; i++) begin
        wb[t][i] = 15;
        xb[t][i] = 15;
      end
    end
    run_job(15, 1'b0, 1'b0, 1'b0, "max");
  endtask

  task automatic test_backpressure;
    load_identity();
    run_job(3, 1'b1, 1'b1, 1'b0, "backpressure");
  endtask

  task automatic test_reset_mid;
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < N; i++) begin
        wb[t][i] = 15;
        xb[t][i] = 13;
      end
    end
    start = 1'b1;
    k_len = KW'(3);
    tick;
    start = 1'b0;
    in_valid = 1'b1;
    set_beat(0);
    tick;
    set_beat(1);
    tick;
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_abort: got busy %b rdy %b vld %b want 0 0 0",
               busy, in_ready, out_valid);
    end
    rst_n = 1'b1;
    tick;
    for (int i = 0; i < N; i++) begin
      wb[0][i] = 2;
      xb[0][i] = 3;
    end
    run_job(1, 1'b0, 1'b0, 1'b0, "reset_mid_fresh");
  endtask

  task automatic test_start_during_unload;
    load_identity();
    run_job(3, 1'b0, 1'b0, 1'b1, "start_in_unload");
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < N; i++) begin
        wb[t][i] = $urandom_range(0, 15);
        xb[t][i] = $urandom_range(0, 15);
      end
    end
    run_job(5, 1'b1, 1'b0, 1'b0, "after_idle");
  endtask

  initial begin
    test_reset();
    test_identity();
    test_kzero();
    test_max();
    test_backpressure();
    test_reset_mid();
    test_start_during_unload();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
